// File: rtl/mem_pkg.sv
// Shared types and constants for the pipelined memory bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MAX_READ_LAT = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line carrying {valid, err, data} for READ_LAT stages.
// Latency: READ_LAT cycles from in_valid to out_valid.
// Backpressure: none; one entry per cycle in, one out.
// Ports: clk/rst_ clock and async active-low clear; in_* enter stage 0,
//        out_* come from the last stage. out_data holds its last valid value.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  // Out-of-range latency settings are clamped into 1..MAX_READ_LAT.
  localparam int LAT = (READ_LAT < 1) ? 1 :
                       (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT;

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    err_q;
  logic [DATA_W-1:0] dat_q [LAT];

  // Data only advances alongside a valid bit, so each stage (and thus
  // out_data) keeps the last real response when bubbles pass through.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      err_q[0] <= in_valid & in_err;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_err   = err_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/mem_pipe_bank.sv
// Single-port synchronous memory with byte-lane writes and pipelined reads.
// Latency: reads respond READ_LAT cycles after acceptance; writes land at the accepting edge.
// Backpressure: req_ready is low only during INIT; in READY one request per cycle, never stalled.
// Ports: req_valid/req_ready handshake with req_write, addr, data_in, wmask;
//        rsp_valid/data_out read response; err out-of-range pulse; init_done when READY.
module mem_pipe_bank
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 5,
  parameter int DEPTH          = 32,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst_,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [lane_count(DATA_W)-1:0] wmask,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           data_out,
  output logic                        err,
  output logic                        init_done
);

  localparam int              LANES   = lane_count(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
  logic            clr_we;
  logic            accept, in_range, wr_en, rd_en;
  logic [DATA_W-1:0] rd_data;
  logic            wr_err_q;
  logic            pipe_err;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, addr} < DEPTH_L;
  assign wr_en    = accept && req_write && in_range;
  assign rd_en    = accept && !req_write;
  // Out-of-range reads return zero rather than whatever aliases in the array.
  assign rd_data  = in_range ? mem[addr] : '0;

  // FSM: INIT (optional zeroing sweep) -> READY.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      INIT: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = 1'b1;
          if (clr_cnt_q == LAST_L) begin
            state_d   = READY;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end else begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign req_ready = (state_q == READY);
  assign init_done = (state_q == READY);

  // Array has no reset; the sweep and accepted writes are its only writers,
  // and they are mutually exclusive because requests are refused in INIT.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[addr][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // Rejected writes flag err one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) wr_err_q <= 1'b0;
    else       wr_err_q <= accept && req_write && !in_range;
  end

  mem_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_      (rst_),
    .in_valid  (rd_en),
    .in_err    (!in_range),
    .in_data   (rd_data),
    .out_valid (rsp_valid),
    .out_err   (pipe_err),
    .out_data  (data_out)
  );

  assign err = pipe_err | wr_err_q;

endmodule

// File: tb/tb_mem_pipe_bank.sv
module tb_mem_pipe_bank;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: defaults (8-bit, depth 32, latency 1, sweep on reset)
  logic       a_valid, a_ready, a_write, a_rsp, a_err, a_done;
  logic [4:0] a_addr;
  logic [7:0] a_din, a_dout;
  logic [0:0] a_mask;

  // Instance B: 32-bit, depth 20, latency 3, no sweep
  logic        b_valid, b_ready, b_write, b_rsp, b_err, b_done;
  logic [4:0]  b_addr;
  logic [31:0] b_din, b_dout;
  logic [3:0]  b_mask;

  mem_pipe_bank u_a (
    .clk(clk), .rst_(rst_),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .addr(a_addr), .data_in(a_din), .wmask(a_mask),
    .rsp_valid(a_rsp), .data_out(a_dout), .err(a_err), .init_done(a_done)
  );

  mem_pipe_bank #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(20), .READ_LAT(3), .CLEAR_ON_RESET(0)
  ) u_b (
    .clk(clk), .rst_(rst_),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .addr(b_addr), .data_in(b_din), .wmask(b_mask),
    .rsp_valid(b_rsp), .data_out(b_dout), .err(b_err), .init_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_op(input logic w, input logic [4:0] ad, input logic [7:0] d, input logic m);
    a_valid = 1'b1; a_write = w; a_addr = ad; a_din = d; a_mask = m;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic b_op(input logic w, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] m);
    b_valid = 1'b1; b_write = w; b_addr = ad; b_din = d; b_mask = m;
    tick();
    b_valid = 1'b0;
  endtask

  // Releases reset; B (no sweep) is ready after one edge, A after 32.
  task automatic release_and_wait(input string tag);
    int cnt;
    rst_ = 1'b1;
    chk({tag, "_b_notready"}, b_ready, 1'b0);
    tick();
    chk({tag, "_b_ready_1cyc"}, b_done, 1'b1);
    cnt = 1;
    while (a_ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk({tag, "_a_sweep_cycles"}, cnt, 32);
    chk({tag, "_a_init_done"}, a_done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ = 1'b0;
    a_valid = 0; a_write = 0; a_addr = 0; a_din = 0; a_mask = 0;
    b_valid = 0; b_write = 0; b_addr = 0; b_din = 0; b_mask = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",  a_ready, 1'b0);
    chk("rst_rsp",    a_rsp,   1'b0);
    chk("rst_dout",   a_dout,  8'h00);
    chk("rst_err",    a_err,   1'b0);
    chk("rst_done",   a_done,  1'b0);
    chk("rst_b_dout", b_dout,  32'h0);

    release_and_wait("init");

    // Sweep result: all 32 words read back zero, one response per cycle.
    for (int i = 0; i < 32; i++) begin
      a_op(1'b0, 5'(i), 8'h00, 1'b0);
      chk($sformatf("sweep_rsp%0d", i), a_rsp, 1'b1);
      chk($sformatf("sweep_dat%0d", i), a_dout, 8'h00);
    end
    tick();
    chk("idle_rsp", a_rsp, 1'b0);

    // Write then read-after-write, latency 1.
    a_op(1'b1, 5'd5, 8'hA5, 1'b1);
    chk("wr_no_rsp", a_rsp, 1'b0);
    chk("wr_no_err", a_err, 1'b0);
    a_op(1'b0, 5'd5, 8'h00, 1'b0);
    chk("raw_rsp", a_rsp, 1'b1);
    chk("raw_dat", a_dout, 8'hA5);
    tick();
    chk("hold_rsp", a_rsp, 1'b0);
    chk("hold_dat", a_dout, 8'hA5);

    // Zero mask is a no-op.
    a_op(1'b1, 5'd5, 8'h3C, 1'b0);
    a_op(1'b0, 5'd5, 8'h00, 1'b0);
    chk("mask0_dat", a_dout, 8'hA5);

    // Top address and a second word for the reset test.
    a_op(1'b1, 5'd31, 8'h7E, 1'b1);
    a_op(1'b1, 5'd6,  8'h66, 1'b1);
    a_op(1'b0, 5'd31, 8'h00, 1'b0);
    chk("top_rsp", a_rsp, 1'b1);
    chk("top_dat", a_dout, 8'h7E);
    chk("top_err", a_err, 1'b0);
    tick();

    // Byte-lane masking on the 32-bit, latency-3 instance.
    b_op(1'b1, 5'd0, 32'h11223344, 4'b1111);
    b_op(1'b1, 5'd0, 32'hFFFFFFFF, 4'b0101);
    b_op(1'b0, 5'd0, 32'h0, 4'b0000);
    chk("mask_lat_e0", b_rsp, 1'b0);
    tick();
    chk("mask_lat_e1", b_rsp, 1'b0);
    tick();
    chk("mask_rsp", b_rsp, 1'b1);
    chk("mask_dat", b_dout, 32'h11FF33FF);
    tick();

    // Back-to-back reads at latency 3.
    b_op(1'b1, 5'd1,  32'hA1, 4'hF);
    b_op(1'b1, 5'd2,  32'hB2, 4'hF);
    b_op(1'b1, 5'd19, 32'hC3, 4'hF);
    b_op(1'b0, 5'd1,  32'h0, 4'h0);
    chk("b2b_e0", b_rsp, 1'b0);
    b_op(1'b0, 5'd2,  32'h0, 4'h0);
    chk("b2b_e1", b_rsp, 1'b0);
    b_op(1'b0, 5'd19, 32'h0, 4'h0);
    chk("b2b_rsp1", b_rsp, 1'b1);
    chk("b2b_dat1", b_dout, 32'hA1);
    tick();
    chk("b2b_rsp2", b_rsp, 1'b1);
    chk("b2b_dat2", b_dout, 32'hB2);
    tick();
    chk("b2b_rsp3", b_rsp, 1'b1);
    chk("b2b_dat3", b_dout, 32'hC3);
    chk("b2b_err3", b_err, 1'b0);
    tick();
    chk("b2b_end", b_rsp, 1'b0);
    chk("b2b_hold", b_dout, 32'hC3);

    // Out-of-range write: err one cycle after acceptance, memory untouched.
    b_op(1'b1, 5'd9,  32'h99, 4'hF);
    b_op(1'b1, 5'd25, 32'hDEAD, 4'hF);
    chk("oor_wr_err", b_err, 1'b1);
    chk("oor_wr_rsp", b_rsp, 1'b0);
    tick();
    chk("oor_wr_err_pulse", b_err, 1'b0);

    // Out-of-range read: zero data with err in the response cycle.
    b_op(1'b0, 5'd25, 32'h0, 4'h0);
    chk("oor_rd_e0_err", b_err, 1'b0);
    tick();
    tick();
    chk("oor_rd_rsp", b_rsp, 1'b1);
    chk("oor_rd_err", b_err, 1'b1);
    chk("oor_rd_dat", b_dout, 32'h0);
    tick();
    chk("oor_rd_err_pulse", b_err, 1'b0);
    b_op(1'b0, 5'd9, 32'h0, 4'h0);
    tick();
    tick();
    chk("oor_stable_dat", b_dout, 32'h99);
    b_op(1'b0, 5'd1, 32'h0, 4'h0);
    tick();
    tick();
    chk("oor_stable_dat1", b_dout, 32'hA1);
    tick();

    // Reset with two reads in flight.
    b_op(1'b0, 5'd1, 32'h0, 4'h0);
    b_op(1'b0, 5'd2, 32'h0, 4'h0);
    rst_ = 1'b0;
    #1;
    chk("mid_rst_b_rsp",   b_rsp,   1'b0);
    chk("mid_rst_b_dout",  b_dout,  32'h0);
    chk("mid_rst_b_ready", b_ready, 1'b0);
    chk("mid_rst_a_ready", a_ready, 1'b0);
    chk("mid_rst_a_dout",  a_dout,  8'h00);
    tick();
    tick();
    chk("mid_rst_no_rsp", b_rsp, 1'b0);

    release_and_wait("rerst");
    chk("rerst_b_no_rsp", b_rsp, 1'b0);

    // Sweep repeated: earlier writes are gone.
    a_op(1'b0, 5'd5, 8'h00, 1'b0);
    chk("rerst_rsp5", a_rsp, 1'b1);
    chk("rerst_dat5", a_dout, 8'h00);
    a_op(1'b0, 5'd6, 8'h00, 1'b0);
    chk("rerst_dat6", a_dout, 8'h00);
    a_op(1'b0, 5'd31, 8'h00, 1'b0);
    chk("rerst_dat31", a_dout, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
